// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Latency: 34 cycles from the start edge to ready_o (2 for divide-by-zero with DIV_BYZERO_FAST_EN).
// Backpressure: the result is held with ready_o=1 until start_i drops. A new start is taken only in FREE.
//
// Ports:
//   clk, rst (async, active-low)
//   signed_div_i  1 = signed DIV, 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high by the execute stage until the result is consumed
//   annul_i       flush of an in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result valid
//
// Optional feature macro: DIV_BYZERO_FAST_EN. When it is defined, a zero divisor takes a
// short path and returns all zeros. When it is undefined, a zero divisor runs all 32 steps.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic        qneg;
  logic        rneg;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] trial;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    // Shift one dividend bit into the partial remainder and try the subtraction.
    // Bit 32 of the result is the borrow; it is set when the divisor does not fit.
    trial        = {1'b0, rem[30:0], quo[31]} - {1'b0, divisor};
    quo_fix      = qneg ? (32'd0 - quo) : quo;
    rem_fix      = rneg ? (32'd0 - rem) : rem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      divisor  <= 32'd0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            cnt     <= 6'd0;
            rem     <= 32'd0;
            quo     <= dividend_abs;
            divisor <= divisor_abs;
            qneg    <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            rneg    <= signed_div_i & opdata1_i[31];
            state   <= ON;
`ifdef DIV_BYZERO_FAST_EN
            if (opdata2_i == 32'd0) state <= BYZERO;
`endif
          end
        end

`ifdef DIV_BYZERO_FAST_EN
        BYZERO: begin
          result_o <= 64'd0;
          ready_o  <= 1'b1;
          state    <= END;
        end
`endif

        ON: begin
          if (annul_i) begin
            // A flush abandons the division. Nothing is reported.
            state <= FREE;
          end else if (cnt != 6'd32) begin
            if (!trial[32]) begin
              rem <= trial[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= {rem[30:0], quo[31]};
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end

        END: begin
          // The result stays held while the execute stage keeps start_i high.
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= 64'd0;
            state    <= FREE;
          end
        end

        default: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          state    <= FREE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider that serves the execute stage's DIV/DIVU requests. The execute stage raises `start_i` with both operands and a signed flag and stalls the pipeline. This block runs a radix-2 restoring division, one quotient bit per cycle. It then returns the remainder and quotient as a 64-bit HI/LO word with `ready_o`, and holds them until the execute stage drops `start_i`.

## Interface
Parameters: none; widths come from `RegBus` (32) and `DoubleRegBus` (64).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `signed_div_i` input 1: 1 = DIV (signed), 0 = DIVU.
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `start_i` input 1: request; `DivStart`=1, `DivStop`=0.
- `annul_i` input 1: flush; abandons an in-flight division.
- `result_o` output 64: {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready_o` output 1: `DivResultReady`=1 / `DivResultNotReady`=0.

## Operation
- Reset (`rst`=0, async):
  - state=FREE, cnt=0, all datapath registers 0.
  - `result_o`=0, `ready_o`=0.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - If `start_i`=1 and `annul_i`=0 and divisor≠0: latch operands and go to ON, cnt=0.
  - Operand latching: if `signed_div_i` and the operand's bit 31 is set, store its two's-complement magnitude; otherwise store it raw.
  - Latch the sign flags: `qneg` = signed & (op1[31]^op2[31]); `rneg` = signed & op1[31].
  - Working register: {rem,quo} = {32'b0, |dividend|}.
  - Divisor==0 with start: go to BYZERO (behaviour set by the macro in Configuration).
  - Otherwise stay in FREE; `ready_o`=0, `result_o`=0.
- ON:
  - `annul_i`=1: go to FREE next edge, `ready_o` stays 0, no result.
  - cnt≠32, one step per edge:
    - t = {rem[30:0],quo[31]} − divisor, computed 33 bits wide.
    - If t[32]=0: rem=t[31:0], quo={quo[30:0],1}.
    - Else: rem={rem[30:0],quo[31]}, quo={quo[30:0],0}.
    - cnt+1.
  - cnt==32:
    - Apply sign fix: quotient = qneg ? −quo : quo; remainder = rneg ? −rem : rem.
    - Register `result_o`, set `ready_o`=1, go to END.
- BYZERO: `result_o`=0; go to END with `ready_o`=1.
- END:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0: go to FREE with `ready_o`=0 and `result_o`=0.
- Operand changes after the start edge are ignored; only latched copies are used.
- Signed 0x80000000 / −1 gives quotient 0x80000000, remainder 0; no trap is raised.

## Timing
- Start sampled at edge E0 (FREE→ON).
- Iterations occur on edges E0+1..E0+32.
- `ready_o` rises after E0+33 and stays high until the first edge at which `start_i`=0.
- Hence a DIV stalls EX for 34 cycles including the issue cycle.
- Divide-by-zero with the macro enabled: BYZERO after E0, `ready_o` high after E0+1.
- `annul_i` takes priority over iteration in ON. It is ignored in FREE: `start_i` together with `annul_i` does not launch. It is ignored in END.
- A fresh `start_i` is accepted in FREE only. Back-to-back divisions therefore need one cycle with `start_i`=0 between them.
- Async reset asserted mid-operation clears all outputs immediately, without waiting for an edge.

## Configuration
- `DIV_BYZERO_FAST_EN` defined:
  - Divisor==0 takes the FREE→BYZERO→END path.
  - Result is all zeros, 2-edge latency.
- Undefined:
  - No BYZERO state; divisor==0 enters ON and runs the full 32 iterations.
  - Every step subtracts 0 and succeeds, so quo=0xFFFFFFFF and rem=|dividend| before the sign fix.
  - Unsigned result is {dividend, 32'hFFFFFFFF}.
  - Signed result with a negative dividend: quotient=0x00000001, remainder=dividend.
  - Latency is the normal 34 cycles.

## Test plan
- DIVU 100/7, `start_i` held until ready → after E0+33, `result_o`=64'h00000002_0000000E, `ready_o`=1. Drop `start_i` → next edge `ready_o`=0 and `result_o`=0.
- DIV −7/2 (0xFFFFFFF9 / 0x00000002) → `result_o`=64'hFFFFFFFF_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → `result_o`=64'h00000000_80000000, 34-cycle latency.
- DIVU 5/0:
  - With `DIV_BYZERO_FAST_EN`: `ready_o` after E0+1, result 0.
  - Without it: `ready_o` after E0+33, result 64'h00000005_FFFFFFFF.
- DIV 1000/3, `annul_i` pulsed on the 10th cycle of ON → FREE next edge, `ready_o` never asserts. A new DIVU 9/3 two cycles later → `result_o`=64'h00000000_00000003.
- Assert `rst`=0 asynchronously at iteration 20 → `ready_o`=0 and `result_o`=0 before the next edge. After `rst` deasserts, state is FREE.
